seg_dec_entry: RTL and testbench
================================

# seg_dec_entry

Four-digit decimal entry block for a board with two push buttons and four 7-segment displays. Button 0 steps a cursor through the digit positions; button 1 increments the selected digit. After the last digit, one more button-0 press loads the entered number, as binary, onto `count_value`. It sits between the board's button/LED pins and downstream logic that consumes the entered value.

## Interface
- `DIGITS`, default 4: number of digits entered per sequence. Legal range 1..4.
- `clk`  in  1: system clock (50 MHz).
- `rst`  in  1: asynchronous, active-low reset.
- `btn`  in  2: active-low push buttons, asynchronous to `clk`. Bit 0 = select/next/load; bit 1 = increment.
- `seg0`  out  8: 7-seg digit 0 (ones, rightmost).
- `seg1`  out  8: 7-seg digit 1 (tens).
- `seg2`  out  8: 7-seg digit 2 (hundreds).
- `seg3`  out  8: 7-seg digit 3 (thousands, leftmost).
- `count_value`  out  14: binary value of the last loaded number, 0..9999.

## Operation
- Input conditioning:
  - Each `btn` bit passes through a 2-FF synchronizer.
  - A falling-edge (press) detector generates a single-cycle pulse per press.
  - A held button produces exactly one pulse.
- Digit registers: DIGITS BCD registers d[0..DIGITS-1], where d[DIGITS-1] is the most significant digit.
- Cursor states:
  - IDLE: no digit selected.
  - SEL_k (k = 1..DIGITS): the k-th entered digit is selected. That digit is d[DIGITS-k], i.e. the first digit entered is the most significant.
- Cursor transitions on a btn0 pulse:
  - IDLE → SEL_1, and all digits clear to 0.
  - SEL_k → SEL_k+1 for k < DIGITS.
  - SEL_DIGITS → IDLE, and the entered number is loaded.
- Load:
  - count_value = Σ d[i]·10^i.
  - Digits are retained for display.
- btn1 pulse:
  - In SEL_k: the selected digit increments modulo 10 (9 → 0).
  - In IDLE: ignored.
- Simultaneous btn0 and btn1 pulses in the same cycle: btn0 acts, btn1 is dropped.
- Segment encoding:
  - Active-low; bit7 = dp, bits6:0 = g..a.
  - Codes 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex).
  - Display positions ≥ DIGITS are blank (FF).
- Reset (asynchronous, `rst` = 0):
  - State = IDLE.
  - All digits = 0.
  - count_value = 0.
  - Active segs = C0; unused segs = FF.
- Reset mid-entry aborts the sequence. count_value is not loaded.

## Timing
- Let `btn` be first sampled low at clock edge N:
  - The press pulse is valid after edge N+2.
  - Digit, cursor, and count_value registers update at edge N+3.
  - seg outputs are registered and update at edge N+4.
- Minimum recognised press: low for 2 consecutive clock edges. Minimum release between presses: 2 edges.
- count_value holds its value between loads and changes only at a load or reset.

## Configuration
- `SEG_DP_CURSOR_EN` defined: the decimal point (bit7 = 0) is lit on the currently selected digit in SEL_k. In that case a selected 5 reads 12.
- `SEG_DP_CURSOR_EN` undefined: bit7 = 1 on all outputs at all times.

## Test plan
- Reset values:
  - `rst` low for 5 cycles → count_value = 0.
  - DIGITS=4: seg0..seg3 = C0.
  - DIGITS=2: seg2 = seg3 = FF.
- Entry of 1-0-5-2:
  - Sequence: btn0, btn1×1, btn0, btn0, btn1×5, btn0, btn1×2, btn0 (50–100 ns pulses).
  - Expected: count_value = 1052; seg3..seg0 = F9, C0, 92, A4.
- Digit wrap:
  - SEL_1 with btn1 pressed 10 times → digit returns to 0 (C0).
  - Then 3 more btn1 presses and completing entry → count_value = 3000.
- btn1 ignored in IDLE:
  - Press btn1 ×3 after reset → all digits stay 0; count_value = 0.
- btn0/btn1 priority and held button:
  - Both pressed in the same cycle from IDLE → SEL_1 with digit 0.
  - btn1 held low for 50 cycles → exactly one increment.
- Reset mid-entry:
  - After entering 1, 0, assert `rst` → state IDLE; count_value keeps its reset value 0.
  - A full entry afterwards loads correctly.

Source files
------------

// File: rtl/seg_dec_entry.sv
// seg_dec_entry: four-digit decimal entry from two push buttons.
// Button 0 moves the cursor from IDLE through SEL_1..SEL_DIGITS and back to IDLE.
// Leaving SEL_DIGITS loads the entered number onto count_value.
// Button 1 increments the selected digit, modulo 10.
// The digits are shown on four active-low 7-segment outputs.
// Optional feature: define SEG_DP_CURSOR_EN to light the decimal point on the
// digit under the cursor. When it is undefined, dp stays dark on every output.
// cursor_state exposes the cursor FSM (0 = IDLE, k = SEL_k) for observation.
module seg_dec_entry #(
  parameter int DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  btn,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [13:0] count_value,
  output logic [2:0]  cursor_state
);

  // Cursor encoding: the state value equals k for SEL_k, and 0 for IDLE.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEL1 = 3'd1;
  localparam logic [2:0] ST_LAST = 3'(DIGITS);

  // Segment patterns for bits 6:0 (g..a), active low.
  function automatic logic [6:0] seg_code(input logic [3:0] v);
    logic [6:0] c;
    c = 7'h7F;
    case (v)
      4'd0: c = 7'h40;
      4'd1: c = 7'h79;
      4'd2: c = 7'h24;
      4'd3: c = 7'h30;
      4'd4: c = 7'h19;
      4'd5: c = 7'h12;
      4'd6: c = 7'h02;
      4'd7: c = 7'h78;
      4'd8: c = 7'h00;
      4'd9: c = 7'h10;
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0] btn_meta;
  logic [1:0] btn_sync;
  logic [1:0] btn_prev;
  logic [1:0] press;

  // Two-flop synchronizer, plus a delayed copy for falling-edge detection.
  // Everything resets to the released (high) level, so a button that is
  // already held when reset ends does not register as a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta <= 2'b11;
      btn_sync <= 2'b11;
      btn_prev <= 2'b11;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  // Registered press pulse: one cycle long for each high-to-low transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press <= 2'b00;
    end else begin
      press <= btn_prev & ~btn_sync;
    end
  end

  logic next_pulse;
  logic inc_pulse;
  assign next_pulse = press[0];
  assign inc_pulse  = press[1];

  // ---------------------------------------------------------------------------
  // Cursor FSM and digit registers
  // ---------------------------------------------------------------------------
  logic [2:0]  state;
  logic [3:0]  digit [4];
  logic [2:0]  sel_idx;
  logic [13:0] entered;

  // SEL_k edits digit DIGITS-k, so the first digit entered is the most
  // significant one. In IDLE this value is never used.
  assign sel_idx = ST_LAST - state;

  // Binary value of the digits, accumulated from the MSB down.
  always_comb begin
    entered = 14'd0;
    for (int i = 3; i >= 0; i--) begin
      if (i < DIGITS) begin
        entered = entered * 14'd10 + {10'd0, digit[i]};
      end
    end
  end

  // Cursor movement, digit editing and load. Button 0 takes priority over
  // button 1 when both pulse in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      count_value <= 14'd0;
      for (int i = 0; i < 4; i++) begin
        digit[i] <= 4'd0;
      end
    end else if (next_pulse) begin
      if (state == ST_IDLE) begin
        state <= ST_SEL1;
        for (int i = 0; i < 4; i++) begin
          digit[i] <= 4'd0;
        end
      end else if (state == ST_LAST) begin
        // The digits are kept so the loaded number stays on the display.
        state       <= ST_IDLE;
        count_value <= entered;
      end else begin
        state <= state + 3'd1;
      end
    end else if (inc_pulse && (state != ST_IDLE)) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_idx == 3'(i)) begin
          digit[i] <= (digit[i] >= 4'd9) ? 4'd0 : digit[i] + 4'd1;
        end
      end
    end
  end

  assign cursor_state = state;

  // ---------------------------------------------------------------------------
  // Segment outputs
  // ---------------------------------------------------------------------------
  logic [7:0] seg_nxt [4];
  logic [7:0] seg_q   [4];

  // Next segment image. Positions beyond DIGITS are blank.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      seg_nxt[i] = 8'hFF;
      if (i < DIGITS) begin
`ifdef SEG_DP_CURSOR_EN
        seg_nxt[i] = {!((state != ST_IDLE) && (sel_idx == 3'(i))), seg_code(digit[i])};
`else
        seg_nxt[i] = {1'b1, seg_code(digit[i])};
`endif
      end
    end
  end

  // Segment outputs are registered, one cycle behind the digit registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        seg_q[i] <= (i < DIGITS) ? 8'hC0 : 8'hFF;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        seg_q[i] <= seg_nxt[i];
      end
    end
  end

  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];

endmodule

// File: tb/tb_seg_dec_entry.sv
// Directed bench for seg_dec_entry. The primary DUT is built with DIGITS=4.
// A second DUT built with DIGITS=2 shares the same stimulus.
module tb_seg_dec_entry;

  logic        clk;
  logic        rst;
  logic [1:0]  btn;
  logic [7:0]  seg0, seg1, seg2, seg3;
  logic [13:0] count_value;
  logic [2:0]  cursor_state;
  logic [7:0]  b_seg0, b_seg1, b_seg2, b_seg3;
  logic [13:0] b_count_value;
  logic [2:0]  b_cursor_state;

  int checks = 0;
  int errors = 0;

  seg_dec_entry #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .count_value(count_value), .cursor_state(cursor_state)
  );

  seg_dec_entry #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .btn(btn),
    .seg0(b_seg0), .seg1(b_seg1), .seg2(b_seg2), .seg3(b_seg3),
    .count_value(b_count_value), .cursor_state(b_cursor_state)
  );

  // Clock and reset: 50 MHz clock, with reset held low from time zero.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Comparison helpers.
  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk14(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks. Inputs change on the falling edge, away from sampling.
  // The button is held for low_cyc cycles, then released for 6 cycles,
  // which leaves time for the registered segment update.
  task automatic press(input int b, input int low_cyc);
    @(negedge clk);
    btn[b] = 1'b0;
    repeat (low_cyc) @(negedge clk);
    btn[b] = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic press_n(input int b, input int n);
    for (int i = 0; i < n; i++) press(b, 4);
  endtask

  task automatic press_both();
    @(negedge clk);
    btn = 2'b00;
    repeat (4) @(negedge clk);
    btn = 2'b11;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_segs(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                            input logic [7:0] e1, input logic [7:0] e0);
    chk8({tag, "_seg3"}, seg3, e3);
    chk8({tag, "_seg2"}, seg2, e2);
    chk8({tag, "_seg1"}, seg1, e1);
    chk8({tag, "_seg0"}, seg0, e0);
  endtask

  initial begin
    rst = 1'b0;
    btn = 2'b11;

    // Reset values, checked while reset is still asserted.
    repeat (5) @(negedge clk);
    chk14("rst_count", count_value, 14'd0);
    chk3("rst_state", cursor_state, 3'd0);
    check_segs("rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    chk8("rst2_seg3", b_seg3, 8'hFF);
    chk8("rst2_seg2", b_seg2, 8'hFF);
    chk8("rst2_seg1", b_seg1, 8'hC0);
    chk8("rst2_seg0", b_seg0, 8'hC0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Presses of button 1 in IDLE are ignored.
    press_n(1, 3);
    chk3("idle_inc_state", cursor_state, 3'd0);
    chk14("idle_inc_count", count_value, 14'd0);
    check_segs("idle_inc", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    // Enter 1-0-5-2.
    press(0, 4);
    chk3("sel1_state", cursor_state, 3'd1);
    press_n(1, 1);
    press(0, 4);
    press(0, 4);
    press_n(1, 5);
    press(0, 4);
    press_n(1, 2);
    chk3("sel4_state", cursor_state, 3'd4);
    chk14("count_before_load", count_value, 14'd0);
    press(0, 4);
    chk14("load_1052", count_value, 14'd1052);
    chk3("load_state", cursor_state, 3'd0);
    check_segs("e1052", 8'hF9, 8'hC0, 8'h92, 8'hA4);
    // The two-digit DUT loaded 1,0 (=10) and then started 2,_ (now in SEL_2).
    chk14("d2_count", b_count_value, 14'd10);
    chk3("d2_state", b_cursor_state, 3'd2);

    // Digit wrap: ten increments return to 0, and three more give 3000.
    press(0, 4);
    chk14("count_hold", count_value, 14'd1052);
    check_segs("clear", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    press_n(1, 10);
    chk8("wrap_seg3", seg3, 8'hC0);
    press_n(1, 3);
    chk8("wrap3_seg3", seg3, 8'hB0);
    press_n(0, 4);
    chk14("load_3000", count_value, 14'd3000);
    chk3("load3000_state", cursor_state, 3'd0);

    // Simultaneous presses: button 0 acts and button 1 is dropped.
    press_both();
    chk3("both_state", cursor_state, 3'd1);
    chk8("both_seg3", seg3, 8'hC0);
    // A button held for 50 cycles yields a single increment.
    press(1, 50);
    chk8("held_seg3", seg3, 8'hF9);
    chk3("held_state", cursor_state, 3'd1);
    press_n(0, 4);
    chk14("load_1000", count_value, 14'd1000);

    // Reset in the middle of an entry aborts the sequence.
    press(0, 4);
    press_n(1, 1);
    press(0, 4);
    press(0, 4);
    chk3("mid_state", cursor_state, 3'd3);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk3("midrst_state", cursor_state, 3'd0);
    chk14("midrst_count", count_value, 14'd0);
    check_segs("midrst", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk14("after_rst_count", count_value, 14'd0);

    // A full entry after reset: 0-0-0-7.
    press_n(0, 4);
    press_n(1, 7);
    press(0, 4);
    chk14("load_7", count_value, 14'd7);
    chk3("load7_state", cursor_state, 3'd0);
    check_segs("e0007", 8'hC0, 8'hC0, 8'hC0, 8'hF8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
